dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port dmem syncram between two requesters: port 0 is the processor data port, port 1 is the debug/loader port.
- Grants at most one access per clock and uses round-robin arbitration.
- Registers the winning request onto the dmem address/data/wren pins.
- Routes read data back to the issuing port after the RAM read latency.
- Sits between the processor and dmem inside the top-level skeleton.

Parameters:
- ADDR_W, 12, dmem word-address width.
- DATA_W, 32, data word width.
- RD_LAT, 1, dmem clock edges from registered address to valid mem_q; legal values are 1 and 2.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held with its fields until p0_gnt.
- p0_wren  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  combinational; request accepted this cycle.
- p0_rvalid  out  1  registered; p0_rdata valid this cycle.
- p0_rdata  out  DATA_W  read data for port 0.
- p1_req, p1_wren, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_address  out  ADDR_W  registered; to dmem address.
- mem_data  out  DATA_W  registered; to dmem data.
- mem_wren  out  1  registered; to dmem wren.
- mem_q  in  DATA_W  from dmem q.

Behaviour:
- Reset (synchronous, active-high): mem_address=0, mem_data=0, mem_wren=0, p0_rvalid=0, p1_rvalid=0, p0_rdata=0, p1_rdata=0.
  - Round-robin pointer last_gnt=1, so port 0 wins the first conflict.
  - Read-tag pipeline is cleared.
  - While reset=1, gnt outputs are 0.
- Arbitration, combinational in cycle t:
  - Only p0_req: grant 0.
  - Only p1_req: grant 1.
  - Both: grant the port != last_gnt.
  - Neither: no grant; last_gnt unchanged.
- At most one of p0_gnt/p1_gnt is high in any cycle.
- Issue: at edge t+1, mem_address, mem_data and mem_wren load the winner's fields.
  - With no grant, mem_wren<=0 and address/data hold their previous values.
  - last_gnt<=winner.
- Read return:
  - A granted read pushes {valid=1, tag=winner} into an RD_LAT+1 deep shift register.
  - When an entry exits, px_rvalid pulses for 1 cycle, with px_rdata<=mem_q, px = tag.
  - Issue-cycle t to rvalid-cycle latency: RD_LAT+1 cycles (2 for RD_LAT=1).
  - rdata of the non-addressed port holds its last value.
- Writes: no response; px_gnt is the only completion indication.
- Throughput: 1 access per cycle; back-to-back reads from either port are fully pipelined. Read-after-write to the same address in consecutive cycles returns the new data (dmem write-first ordering).
- Handshake: a requester keeps req, wren, addr and wdata stable from assert until the cycle its gnt=1. It may assert the next request in the following cycle.
- Fairness: two continuously requesting ports alternate strictly (0,1,0,1,...); neither waits more than 1 cycle.
- Reset mid-operation: all in-flight reads are discarded; no rvalid is emitted for any read granted before reset.
- Lone requester: gets a grant every cycle regardless of last_gnt.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - PORT_PROC=0, PORT_DBG=1.
  - Default ADDR_W/DATA_W/RD_LAT.
  - Read-tag struct {valid, tag}.
- One sub-module: rd_tag_pipe, a parameterised RD_LAT+1 shift register of read tags with synchronous clear.

Test Plan:
- Reset, then p0 writes addr 0x010 data 0xDEADBEEF:
  - p0_gnt=1 in the request cycle.
  - Next cycle: mem_wren=1, mem_address=0x010, mem_data=0xDEADBEEF.
- p0 reads 0x010 after that write: p0_rvalid=1 two cycles after p0_gnt, p0_rdata=0xDEADBEEF, p1_rvalid stays 0.
- Both ports request reads every cycle for 6 cycles (p0 addr 0x001, p1 addr 0x002) from reset:
  - Grants go 0,1,0,1,0,1.
  - mem_address sequence is 0x001,0x002,...
  - rvalids alternate with the matching data.
- p1 alone requests 4 consecutive writes to 0x100..0x103 (data 1..4): p1_gnt=1 in all 4 cycles; dmem holds 1..4.
- p0 read granted, then reset asserted in the next cycle: no p0_rvalid ever appears; all outputs return to 0.
- Run with RD_LAT=2: p1 read of preloaded 0x020=0x12345678 gives p1_rvalid 3 cycles after p1_gnt, with the correct data.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem port arbiter.
//   - Port identifiers: processor data port and debug/loader port.
//   - Default geometry: word-address width, data width, dmem read latency.
//   - rd_tag_t: one slot of the read-return pipeline. It holds a valid bit
//     and the port that issued the read.
package dmem_arb_pkg;

    localparam logic PORT_PROC = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 1;

    typedef struct packed {
        logic valid;
        logic tag;
    } rd_tag_t;

    // Round-robin pick between two requesters. The port that did not win
    // last time wins a conflict. The result is only meaningful when at
    // least one request is high.
    function automatic logic rr_pick(input logic req0, input logic req1,
                                     input logic last_gnt);
        logic win;
        if (req0 && req1) begin
            win = (last_gnt == PORT_PROC) ? PORT_DBG : PORT_PROC;
        end else if (req1) begin
            win = PORT_DBG;
        end else begin
            win = PORT_PROC;
        end
        return win;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register of read tags that tracks reads in flight through dmem.
//   clock   : system clock; the register shifts on every rising edge.
//   reset   : synchronous active-high clear of every slot.
//   push_i  : tag entering slot 0 (valid=0 when no read is issued).
//   tap_o   : slot DEPTH-2. Its tag marks the cycle in which mem_q carries
//             that read's data.
//   out_o   : slot DEPTH-1, the exiting entry. It marks the cycle in which the
//             read data is presented to the requester.
module rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_RD_LAT + 1
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t push_i,
    output rd_tag_t tap_o,
    output rd_tag_t out_o
);

    rd_tag_t stage_q [DEPTH];
    rd_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = push_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tap_o = stage_q[DEPTH-2];
    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port dmem syncram.
// Port 0 is the processor data port. Port 1 is the debug/loader port.
//   clock, reset        : system clock, synchronous active-high reset.
//   pN_req/wren/addr/wdata : request fields, held until pN_gnt.
//   pN_gnt              : combinational accept, at most one per cycle.
//   pN_rvalid/pN_rdata  : read return, RD_LAT+1 cycles after the grant.
//   mem_address/data/wren : registered dmem pins, loaded from the winner.
//   mem_q               : dmem read data, valid RD_LAT edges after the
//                         registered address is first presented.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_wren,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_wren,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    logic              last_gnt_q,    last_gnt_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_q,    mem_data_d;
    logic              mem_wren_q,    mem_wren_d;
    logic [DATA_W-1:0] p0_rdata_q,    p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q,    p1_rdata_d;

    logic    any_req;
    logic    winner;
    logic    gnt0;
    logic    gnt1;
    logic    win_wren;
    rd_tag_t push;
    rd_tag_t tap;
    rd_tag_t out;

    // Arbitration. Grants are held low during reset so that nothing is
    // accepted while the state is being cleared.
    always_comb begin
        any_req = (p0_req || p1_req) && !reset;
        winner  = rr_pick(p0_req, p1_req, last_gnt_q);
        gnt0    = any_req && (winner == PORT_PROC);
        gnt1    = any_req && (winner == PORT_DBG);
    end

    // Issue stage: load the winner onto the dmem pins. With no grant, only
    // wren drops and the address and data hold.
    always_comb begin
        last_gnt_d    = last_gnt_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        win_wren      = 1'b0;
        if (gnt0) begin
            mem_address_d = p0_addr;
            mem_data_d    = p0_wdata;
            mem_wren_d    = p0_wren;
            win_wren      = p0_wren;
            last_gnt_d    = PORT_PROC;
        end else if (gnt1) begin
            mem_address_d = p1_addr;
            mem_data_d    = p1_wdata;
            mem_wren_d    = p1_wren;
            win_wren      = p1_wren;
            last_gnt_d    = PORT_DBG;
        end
        push.valid = (gnt0 || gnt1) && !win_wren;
        push.tag   = winner;
    end

    // One slot per edge from grant to rvalid. The capture register below is
    // fed from the tap slot, so rdata and the exiting tag line up.
    rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_rd_tag_pipe (
        .clock  (clock),
        .reset  (reset),
        .push_i (push),
        .tap_o  (tap),
        .out_o  (out)
    );

    // Return stage: capture mem_q only for the port that issued the read.
    // The other port keeps its last data.
    always_comb begin
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        if (tap.valid && (tap.tag == PORT_PROC)) begin
            p0_rdata_d = mem_q;
        end
        if (tap.valid && (tap.tag == PORT_DBG)) begin
            p1_rdata_d = mem_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt_q    <= PORT_DBG;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
        end else begin
            last_gnt_q    <= last_gnt_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            p0_rdata_q    <= p0_rdata_d;
            p1_rdata_q    <= p1_rdata_d;
        end
    end

    assign p0_gnt      = gnt0;
    assign p1_gnt      = gnt1;
    assign p0_rvalid   = out.valid && (out.tag == PORT_PROC);
    assign p1_rvalid   = out.valid && (out.tag == PORT_DBG);
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- instance A: RD_LAT = 1 ----------------
    logic          a_reset;
    logic          a_p0_req, a_p0_wren, a_p0_gnt, a_p0_rvalid;
    logic [AW-1:0] a_p0_addr;
    logic [DW-1:0] a_p0_wdata, a_p0_rdata;
    logic          a_p1_req, a_p1_wren, a_p1_gnt, a_p1_rvalid;
    logic [AW-1:0] a_p1_addr;
    logic [DW-1:0] a_p1_wdata, a_p1_rdata;
    logic [AW-1:0] a_mem_address;
    logic [DW-1:0] a_mem_data, a_mem_q;
    logic          a_mem_wren;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
        .clock(clock), .reset(a_reset),
        .p0_req(a_p0_req), .p0_wren(a_p0_wren), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
        .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
        .p1_req(a_p1_req), .p1_wren(a_p1_wren), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
        .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
        .mem_address(a_mem_address), .mem_data(a_mem_data), .mem_wren(a_mem_wren),
        .mem_q(a_mem_q)
    );

    // dmem model, 1 edge of latency: write at the edge, read the array asynchronously.
    logic [DW-1:0] ram_a [0:4095];
    always @(posedge clock) if (a_mem_wren) ram_a[a_mem_address] <= a_mem_data;
    assign a_mem_q = ram_a[a_mem_address];

    // ---------------- instance B: RD_LAT = 2 ----------------
    logic          b_reset;
    logic          b_p0_req, b_p0_wren, b_p0_gnt, b_p0_rvalid;
    logic [AW-1:0] b_p0_addr;
    logic [DW-1:0] b_p0_wdata, b_p0_rdata;
    logic          b_p1_req, b_p1_wren, b_p1_gnt, b_p1_rvalid;
    logic [AW-1:0] b_p1_addr;
    logic [DW-1:0] b_p1_wdata, b_p1_rdata;
    logic [AW-1:0] b_mem_address;
    logic [DW-1:0] b_mem_data, b_mem_q;
    logic          b_mem_wren;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut_b (
        .clock(clock), .reset(b_reset),
        .p0_req(b_p0_req), .p0_wren(b_p0_wren), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
        .p1_req(b_p1_req), .p1_wren(b_p1_wren), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
        .mem_address(b_mem_address), .mem_data(b_mem_data), .mem_wren(b_mem_wren),
        .mem_q(b_mem_q)
    );

    logic [DW-1:0] ram_b [0:4095];
    logic [DW-1:0] b_q_r;
    always @(posedge clock) begin
        if (b_mem_wren) ram_b[b_mem_address] <= b_mem_data;
        b_q_r <= ram_b[b_mem_address];
    end
    assign b_mem_q = b_q_r;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drv0(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_p0_req = r; a_p0_wren = w; a_p0_addr = ad; a_p0_wdata = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_p1_req = r; a_p1_wren = w; a_p1_addr = ad; a_p1_wdata = d;
    endtask

    task automatic reset_a;
        drv0(0, 0, '0, '0);
        drv1(0, 0, '0, '0);
        a_reset = 1'b1;
        tick;
        tick;
        a_reset = 1'b0;
    endtask

    // Table of arbitration vectors, applied one per cycle from reset.
    typedef struct {
        logic r0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic r1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic g0; logic g1;
        logic [AW-1:0] ea; logic [DW-1:0] ed; logic ew;
    } vec_t;
    vec_t tbl [8];

    // Scoreboard entry for an outstanding read.
    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    rd_exp_t       rq [$];
    logic [DW-1:0] mmem [int];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int            win;
        int            mlast;
        logic          w;
        logic [AW-1:0] ad;
        logic [DW-1:0] dd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_wren;
        logic          ex0, ex1;
        int            ep;

        b_p0_req = 0; b_p0_wren = 0; b_p0_addr = '0; b_p0_wdata = '0;
        b_p1_req = 0; b_p1_wren = 0; b_p1_addr = '0; b_p1_wdata = '0;
        b_reset = 1'b1;

        // Reset with both ports requesting: no grants, all outputs zero.
        a_reset = 1'b1;
        drv0(1, 1, 12'h055, 32'hAAAA5555);
        drv1(1, 1, 12'h066, 32'h5555AAAA);
        tick;
        #1;
        chk("rst_gnt0", a_p0_gnt, 0);
        chk("rst_gnt1", a_p1_gnt, 0);
        tick;
        chk("rst_maddr", a_mem_address, 0);
        chk("rst_mdata", a_mem_data, 0);
        chk("rst_mwren", a_mem_wren, 0);
        chk("rst_rv0", a_p0_rvalid, 0);
        chk("rst_rv1", a_p1_rvalid, 0);
        chk("rst_rd0", a_p0_rdata, 0);
        chk("rst_rd1", a_p1_rdata, 0);
        drv0(0, 0, '0, '0);
        drv1(0, 0, '0, '0);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // p0 writes, then reads the same address back.
        drv0(1, 1, 12'h010, 32'hDEADBEEF);
        #1;
        chk("wr_gnt0", a_p0_gnt, 1);
        chk("wr_gnt1", a_p1_gnt, 0);
        tick;
        chk("wr_mwren", a_mem_wren, 1);
        chk("wr_maddr", a_mem_address, 12'h010);
        chk("wr_mdata", a_mem_data, 32'hDEADBEEF);
        drv0(1, 0, 12'h010, 32'h0);
        #1;
        chk("rd_gnt0", a_p0_gnt, 1);
        tick;
        drv0(0, 0, '0, '0);
        chk("rd_rv0_early", a_p0_rvalid, 0);
        tick;
        chk("rd_rv0", a_p0_rvalid, 1);
        chk("rd_data0", a_p0_rdata, 32'hDEADBEEF);
        chk("rd_rv1", a_p1_rvalid, 0);
        tick;
        chk("rd_rv0_pulse", a_p0_rvalid, 0);

        // Both ports read continuously: strict alternation, pipelined returns.
        drv0(1, 1, 12'h001, 32'h11110001);
        tick;
        drv0(0, 0, '0, '0);
        drv1(1, 1, 12'h002, 32'h22220002);
        tick;
        reset_a;
        for (int i = 0; i < 9; i++) begin
            if (i < 6) begin
                drv0(1, 0, 12'h001, '0);
                drv1(1, 0, 12'h002, '0);
            end else begin
                drv0(0, 0, '0, '0);
                drv1(0, 0, '0, '0);
            end
            #1;
            if (i < 6) begin
                chk("alt_gnt0", a_p0_gnt, (i % 2) == 0);
                chk("alt_gnt1", a_p1_gnt, (i % 2) == 1);
            end
            if (i >= 1 && i <= 6)
                chk("alt_maddr", a_mem_address, ((i - 1) % 2 == 0) ? 12'h001 : 12'h002);
            if (i >= 2 && i <= 7) begin
                ep = (i - 2) % 2;
                chk("alt_rv0", a_p0_rvalid, ep == 0);
                chk("alt_rv1", a_p1_rvalid, ep == 1);
                if (ep == 0) chk("alt_rd0", a_p0_rdata, 32'h11110001);
                else         chk("alt_rd1", a_p1_rdata, 32'h22220002);
            end
            tick;
        end

        // p1 alone writes four consecutive words.
        for (int k = 0; k < 4; k++) begin
            drv1(1, 1, AW'(12'h100 + k), DW'(k + 1));
            #1;
            chk("burst_gnt1", a_p1_gnt, 1);
            tick;
        end
        drv1(0, 0, '0, '0);
        tick;
        for (int k = 0; k < 4; k++)
            chk("burst_ram", ram_a[12'h100 + k], DW'(k + 1));

        // Read granted, reset in the following cycle: the read never returns.
        drv0(1, 0, 12'h010, '0);
        #1;
        chk("rstmid_gnt0", a_p0_gnt, 1);
        tick;
        drv0(0, 0, '0, '0);
        drv1(1, 0, 12'h002, '0);
        a_reset = 1'b1;
        #1;
        chk("rstmid_gnt1_in_reset", a_p1_gnt, 0);
        tick;
        a_reset = 1'b0;
        drv1(0, 0, '0, '0);
        chk("rstmid_maddr", a_mem_address, 0);
        chk("rstmid_rd0", a_p0_rdata, 0);
        chk("rstmid_rd1", a_p1_rdata, 0);
        for (int k = 0; k < 4; k++) begin
            chk("rstmid_rv0", a_p0_rvalid, 0);
            tick;
        end

        // Table-driven arbitration sequence, starting from reset (last_gnt=1).
        tbl[0] = '{1, 0, 12'h0A1, 32'h0,  1, 0, 12'h0B2, 32'h0,  1, 0, 12'h0A1, 32'h0,  0};
        tbl[1] = '{1, 0, 12'h0A1, 32'h0,  1, 0, 12'h0B2, 32'h0,  0, 1, 12'h0B2, 32'h0,  0};
        tbl[2] = '{0, 0, 12'h000, 32'h0,  1, 1, 12'h0C3, 32'h55, 0, 1, 12'h0C3, 32'h55, 1};
        tbl[3] = '{1, 1, 12'h0D4, 32'h77, 0, 0, 12'h000, 32'h0,  1, 0, 12'h0D4, 32'h77, 1};
        tbl[4] = '{1, 0, 12'h0A1, 32'h0,  0, 0, 12'h000, 32'h0,  1, 0, 12'h0A1, 32'h0,  0};
        tbl[5] = '{0, 0, 12'h000, 32'h0,  0, 0, 12'h000, 32'h0,  0, 0, 12'h0A1, 32'h0,  0};
        tbl[6] = '{1, 0, 12'h0A1, 32'h0,  1, 0, 12'h0B2, 32'h0,  0, 1, 12'h0B2, 32'h0,  0};
        tbl[7] = '{1, 0, 12'h0A1, 32'h0,  0, 0, 12'h000, 32'h0,  1, 0, 12'h0A1, 32'h0,  0};
        reset_a;
        for (int i = 0; i < 8; i++) begin
            drv0(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
            drv1(tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("tbl%0d_gnt0", i), a_p0_gnt, tbl[i].g0);
            chk($sformatf("tbl%0d_gnt1", i), a_p1_gnt, tbl[i].g1);
            tick;
            chk($sformatf("tbl%0d_maddr", i), a_mem_address, tbl[i].ea);
            chk($sformatf("tbl%0d_mdata", i), a_mem_data, tbl[i].ed);
            chk($sformatf("tbl%0d_mwren", i), a_mem_wren, tbl[i].ew);
        end

        // Randomized traffic against a transaction-level reference model.
        drv0(0, 0, '0, '0);
        drv1(0, 0, '0, '0);
        for (int k = 0; k < 16; k++) begin
            drv0(1, 1, AW'(12'h300 + k), $urandom);
            mmem[12'h300 + k] = a_p0_wdata;
            tick;
        end
        reset_a;
        mlast  = 1;
        e_addr = '0; e_data = '0; e_wren = 1'b0;
        drv0($urandom_range(0, 3) != 0, 1'($urandom), AW'(12'h300 + $urandom_range(0, 15)), $urandom);
        drv1($urandom_range(0, 3) != 0, 1'($urandom), AW'(12'h300 + $urandom_range(0, 15)), $urandom);
        for (int n = 0; n < 400; n++) begin
            #1;
            win = -1;
            if (a_p0_req && a_p1_req) win = (mlast == 0) ? 1 : 0;
            else if (a_p0_req)        win = 0;
            else if (a_p1_req)        win = 1;
            chk("rnd_gnt0", a_p0_gnt, win == 0);
            chk("rnd_gnt1", a_p1_gnt, win == 1);
            chk("rnd_maddr", a_mem_address, e_addr);
            chk("rnd_mdata", a_mem_data, e_data);
            chk("rnd_mwren", a_mem_wren, e_wren);
            ex0 = (rq.size() > 0) && (rq[0].due == n) && (rq[0].port == 0);
            ex1 = (rq.size() > 0) && (rq[0].due == n) && (rq[0].port == 1);
            chk("rnd_rv0", a_p0_rvalid, ex0);
            chk("rnd_rv1", a_p1_rvalid, ex1);
            if (ex0) chk("rnd_rd0", a_p0_rdata, rq[0].data);
            if (ex1) chk("rnd_rd1", a_p1_rdata, rq[0].data);
            if (ex0 || ex1) void'(rq.pop_front());
            e_wren = 1'b0;
            if (win >= 0) begin
                mlast = win;
                w  = (win == 0) ? a_p0_wren  : a_p1_wren;
                ad = (win == 0) ? a_p0_addr  : a_p1_addr;
                dd = (win == 0) ? a_p0_wdata : a_p1_wdata;
                e_addr = ad;
                e_data = dd;
                e_wren = w;
                if (w) mmem[int'(ad)] = dd;
                else   rq.push_back('{win, mmem[int'(ad)], n + 2});
            end
            tick;
            if (win == 0 || !a_p0_req)
                drv0($urandom_range(0, 3) != 0, 1'($urandom), AW'(12'h300 + $urandom_range(0, 15)), $urandom);
            if (win == 1 || !a_p1_req)
                drv1($urandom_range(0, 3) != 0, 1'($urandom), AW'(12'h300 + $urandom_range(0, 15)), $urandom);
        end
        drv0(0, 0, '0, '0);
        drv1(0, 0, '0, '0);

        // RD_LAT = 2: preload through p1, then read it back through p1.
        b_p1_req = 1; b_p1_wren = 1; b_p1_addr = 12'h020; b_p1_wdata = 32'h12345678;
        #1;
        chk("l2_wr_gnt1", b_p1_gnt, 1);
        tick;
        b_p1_req = 0; b_p1_wren = 0;
        tick;
        b_p1_req = 1; b_p1_wren = 0; b_p1_addr = 12'h020; b_p1_wdata = '0;
        #1;
        chk("l2_rd_gnt1", b_p1_gnt, 1);
        tick;
        b_p1_req = 0;
        chk("l2_rv1_c1", b_p1_rvalid, 0);
        tick;
        chk("l2_rv1_c2", b_p1_rvalid, 0);
        tick;
        chk("l2_rv1_c3", b_p1_rvalid, 1);
        chk("l2_rd1", b_p1_rdata, 32'h12345678);
        chk("l2_rv0", b_p0_rvalid, 0);
        tick;
        chk("l2_rv1_pulse", b_p1_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
